// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encodings and width helpers for the Morse calibrator
package morse_pkg;

  localparam int DEFAULT_CW = 31;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_DOT  = 3'd2,
    ST_DASH = 3'd3,
    ST_CALC = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Sums hold up to n_presses full-scale durations without overflow.
  function automatic int sum_width(input int cw, input int n_presses);
    return cw + $clog2(n_presses);
  endfunction

endpackage

// File: rtl/morse_calibrator_if.sv
// rtl/morse_calibrator_if.sv - key/start inputs and calibration results of the Morse calibrator
interface morse_calibrator_if #(
  parameter int CW       = 31,
  parameter int N_SYM    = 4,
  parameter int N_GROUPS = 4
);
  logic                             Start;
  logic                             Key;
  logic [CW-1:0]                    Dot_len;
  logic [CW-1:0]                    Dash_len;
  logic [CW-1:0]                    Threshold;
  logic [CW-1:0]                    Timeout;
  logic                             Busy;
  logic                             Done;
  logic                             Valid;
  logic                             Error;
  logic [2:0]                       state;
  logic [$clog2(N_SYM+1)-1:0]       sym_cnt;
  logic [$clog2(N_GROUPS+1)-1:0]    group_cnt;

  modport master (
    output Start, Key,
    input  Dot_len, Dash_len, Threshold, Timeout, Busy, Done, Valid, Error,
    input  state, sym_cnt, group_cnt
  );

  modport slave (
    input  Start, Key,
    output Dot_len, Dash_len, Threshold, Timeout, Busy, Done, Valid, Error,
    output state, sym_cnt, group_cnt
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle, x/0 gives all ones
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CNTW = $clog2(W + 1);

  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W:0]      trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // A zero divisor always passes the trial subtraction, so the quotient saturates to all ones.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[W-1]};
    if (start && !busy_q) begin
      rem_d  = '0;
      quo_d  = dividend;
      dsr_d  = divisor;
      cnt_d  = CNTW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = W'(trial - {1'b0, dsr_q});
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/morse_calibrator.sv
// rtl/morse_calibrator.sv - measures keyed dot/dash/gap durations and derives decoder timing
module morse_calibrator
  import morse_pkg::*;
#(
  parameter int            CW       = DEFAULT_CW,
  parameter int            N_SYM    = 4,
  parameter int            N_GROUPS = 4,
  parameter logic [CW-1:0] MAX_IDLE = {{(CW-1){1'b1}}, 1'b0}
) (
  input  logic              Clk,
  input  logic              Reset,
  morse_calibrator_if.slave bus
);
  localparam int            SW      = sum_width(CW, N_SYM * N_GROUPS);
  localparam int            SCW     = $clog2(N_SYM + 1);
  localparam int            GCW     = $clog2(N_GROUPS + 1);
  localparam logic [SW-1:0] HALF_N  = SW'(N_SYM * N_GROUPS / 2);
  localparam logic [SW-1:0] GAP_N   = SW'(N_SYM * N_GROUPS - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic            key_q, key_d;
  logic            first_q, first_d;
  logic [CW-1:0]   press_cnt_q, press_cnt_d;
  logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [SW-1:0]   dot_sum_q, dot_sum_d;
  logic [SW-1:0]   dash_sum_q, dash_sum_d;
  logic [SW-1:0]   gap_sum_q, gap_sum_d;
  logic [SCW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [GCW-1:0]  group_cnt_q, group_cnt_d;
  logic [CW-1:0]   dot_len_q, dot_len_d;
  logic [CW-1:0]   dash_len_q, dash_len_d;
  logic [CW-1:0]   thr_q, thr_d;
  logic [CW-1:0]   timeout_q, timeout_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic            done_q, done_d;
  logic [1:0]      step_q, step_d;
  logic            launched_q, launched_d;
  logic            busy;

  logic            div_start;
  logic [SW-1:0]   div_dividend;
  logic [SW-1:0]   div_divisor;
  logic            div_busy;
  logic            div_done;
  logic [SW-1:0]   div_quot;
  logic            div_quot_unused;
  logic [CW:0]     thr_sum;
  logic [SCW-1:0]  sym_next;
  logic [GCW-1:0]  group_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  seq_divider #(.W(SW)) u_div (
    .clk      (Clk),
    .rst      (Reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Quotients are means of CW-bit durations, so the upper bits are always zero.
  assign div_quot_unused = ^div_quot[SW-1:CW];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      key_q       <= 1'b0;
      first_q     <= 1'b0;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      dot_sum_q   <= '0;
      dash_sum_q  <= '0;
      gap_sum_q   <= '0;
      sym_cnt_q   <= '0;
      group_cnt_q <= '0;
      dot_len_q   <= '0;
      dash_len_q  <= '0;
      thr_q       <= '0;
      timeout_q   <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= '0;
      launched_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      first_q     <= first_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dot_sum_q   <= dot_sum_d;
      dash_sum_q  <= dash_sum_d;
      gap_sum_q   <= gap_sum_d;
      sym_cnt_q   <= sym_cnt_d;
      group_cnt_q <= group_cnt_d;
      dot_len_q   <= dot_len_d;
      dash_len_q  <= dash_len_d;
      thr_q       <= thr_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      done_q      <= done_d;
      step_q      <= step_d;
      launched_q  <= launched_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = bus.Key;
    first_d      = first_q;
    press_cnt_d  = press_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dot_sum_d    = dot_sum_q;
    dash_sum_d   = dash_sum_q;
    gap_sum_d    = gap_sum_q;
    sym_cnt_d    = sym_cnt_q;
    group_cnt_d  = group_cnt_q;
    dot_len_d    = dot_len_q;
    dash_len_d   = dash_len_q;
    thr_d        = thr_q;
    timeout_d    = timeout_q;
    valid_d      = valid_q;
    error_d      = error_q;
    done_d       = 1'b0;
    step_d       = step_q;
    launched_d   = launched_q;
    div_start    = 1'b0;
    div_dividend = (step_q == 2'd0) ? dot_sum_q : (step_q == 2'd1) ? dash_sum_q : gap_sum_q;
    div_divisor  = (step_q == 2'd2) ? GAP_N : HALF_N;
    thr_sum      = {1'b0, dot_len_q} + {1'b0, dash_len_q};
    sym_next     = sym_cnt_q + SCW'(1);
    group_next   = group_cnt_q + GCW'(1);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          state_d     = ST_ARM;
          first_d     = 1'b0;
          press_cnt_d = '0;
          gap_cnt_d   = '0;
          dot_sum_d   = '0;
          dash_sum_d  = '0;
          gap_sum_d   = '0;
          sym_cnt_d   = '0;
          group_cnt_d = '0;
          dot_len_d   = '0;
          dash_len_d  = '0;
          thr_d       = '0;
          timeout_d   = '0;
          valid_d     = 1'b0;
          error_d     = 1'b0;
          step_d      = '0;
          launched_d  = 1'b0;
        end
      end
      ST_ARM: begin
        if (!bus.Key) state_d = ST_DOT;
      end
      ST_DOT, ST_DASH: begin
        if (bus.Key) begin
          press_cnt_d = key_q ? sat_inc(press_cnt_q) : CW'(1);
          if (!key_q) begin
            if (first_q) gap_sum_d = gap_sum_q + SW'(gap_cnt_q);
            first_d = 1'b1;
          end
        end else begin
          if (first_q) gap_cnt_d = key_q ? CW'(1) : sat_inc(gap_cnt_q);
          if (key_q) begin
            if (state_q == ST_DOT) dot_sum_d = dot_sum_q + SW'(press_cnt_q);
            else                   dash_sum_d = dash_sum_q + SW'(press_cnt_q);
            sym_cnt_d = sym_next;
            if (sym_next == SCW'(N_SYM)) begin
              sym_cnt_d   = '0;
              group_cnt_d = group_next;
              if (group_next == GCW'(N_GROUPS)) state_d = ST_CALC;
              else state_d = (state_q == ST_DOT) ? ST_DASH : ST_DOT;
            end
          end
        end
        if (press_cnt_q > MAX_IDLE || gap_cnt_q > MAX_IDLE) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      ST_CALC: begin
        div_start = !launched_q && !div_busy;
        if (div_start) launched_d = 1'b1;
        if (div_done) begin
          launched_d = 1'b0;
          step_d     = step_q + 2'd1;
          unique case (step_q)
            2'd0:    dot_len_d = div_quot[CW-1:0];
            2'd1:    dash_len_d = div_quot[CW-1:0];
            default: begin
              timeout_d = div_quot[CW-1:0];
              thr_d     = CW'(thr_sum >> 1);
              // Dashes must be at least twice as long as dots to be separable.
              if (({1'b0, dash_len_q} < {dot_len_q, 1'b0}) || dot_len_q == '0) begin
                error_d = 1'b1;
                valid_d = 1'b0;
              end else begin
                error_d = 1'b0;
                valid_d = 1'b1;
              end
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ARM) || (state_q == ST_DOT) ||
           (state_q == ST_DASH) || (state_q == ST_CALC);
  end

  assign bus.Dot_len   = dot_len_q;
  assign bus.Dash_len  = dash_len_q;
  assign bus.Threshold = thr_q;
  assign bus.Timeout   = timeout_q;
  assign bus.Busy      = busy;
  assign bus.Done      = done_q;
  assign bus.Valid     = valid_q;
  assign bus.Error     = error_q;
  assign bus.state     = state_q;
  assign bus.sym_cnt   = sym_cnt_q;
  assign bus.group_cnt = group_cnt_q;
endmodule

// File: tb/tb_morse_calibrator.sv
// tb/tb_morse_calibrator.sv - randomized scoreboard bench for morse_calibrator
module tb_morse_calibrator;
  localparam int CW       = 16;
  localparam int N_SYM    = 4;
  localparam int N_GROUPS = 4;
  localparam int NP       = N_SYM * N_GROUPS;

  typedef struct {
    longint dot;
    longint dash;
    longint thr;
    longint tmo;
    longint valid;
    longint error;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;
  int   pl[NP];
  int   gl[NP];
  exp_t exp_q[$];

  morse_calibrator_if #(.CW(CW), .N_SYM(N_SYM), .N_GROUPS(N_GROUPS)) bus ();

  morse_calibrator #(
    .CW(CW), .N_SYM(N_SYM), .N_GROUPS(N_GROUPS), .MAX_IDLE(16'd200)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Reference: means over the press list, dots in even groups, gaps between consecutive presses.
  function automatic exp_t model();
    exp_t   e;
    longint ds = 0, hs = 0, gs = 0;
    for (int i = 0; i < NP; i++) begin
      if (((i / N_SYM) % 2) == 0) ds += pl[i];
      else hs += pl[i];
      if (i < NP - 1) gs += gl[i];
    end
    e.dot   = ds / (NP / 2);
    e.dash  = hs / (NP / 2);
    e.tmo   = gs / (NP - 1);
    e.thr   = (e.dot + e.dash) / 2;
    e.error = (e.dash < 2 * e.dot || e.dot == 0) ? 1 : 0;
    e.valid = 1 - e.error;
    return e;
  endfunction

  task automatic key_presses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.Key = 1'b1;
      tick(pl[i]);
      bus.Key = 1'b0;
      if (i < NP - 1) tick(gl[i]);
    end
  endtask

  task automatic start_pulse();
    bus.Start = 1'b1;
    tick(1);
    bus.Start = 1'b0;
  endtask

  task automatic run_session(input string tag, input bit hold_key);
    int n;
    exp_q.push_back(model());
    bus.Key = hold_key;
    start_pulse();
    check({tag, "_start_error"}, bus.Error, 0);
    check({tag, "_start_valid"}, bus.Valid, 0);
    if (hold_key) begin
      tick(49);
      check({tag, "_arm_wait"}, bus.state, 1);
      check({tag, "_arm_busy"}, bus.Busy, 1);
      bus.Key = 1'b0;
    end
    tick(3);
    key_presses(NP);
    n = 0;
    while (bus.state != 3'd5 && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_reach_done"}, (n < 200) ? 1 : 0, 1);
    check({tag, "_idle_after"}, bus.Busy, 0);
    tick(2);
  endtask

  task automatic fill(input int d, input int h, input int g);
    for (int i = 0; i < NP; i++) begin
      pl[i] = (((i / N_SYM) % 2) == 0) ? d : h;
      gl[i] = g;
    end
  endtask

  // Monitor: every Done pops one expectation; Done must drop on the following cycle.
  initial begin : monitor
    exp_t e;
    bit   prev_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (prev_done) check("done_one_cycle", bus.Done, 0);
        if (bus.Done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("dot_len", bus.Dot_len, e.dot);
            check("dash_len", bus.Dash_len, e.dash);
            check("threshold", bus.Threshold, e.thr);
            check("timeout", bus.Timeout, e.tmo);
            check("valid", bus.Valid, e.valid);
            check("error", bus.Error, e.error);
          end
        end
      end
      prev_done = bus.Done;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Key = 1'b0;
    tick(3);
    Reset = 1'b0;
    check("rst_state", bus.state, 0);
    check("rst_valid", bus.Valid, 0);
    check("rst_error", bus.Error, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_dot", bus.Dot_len, 0);
    tick(2);

    fill(10, 30, 12);
    run_session("nominal", 1'b0);

    fill(10, 30, 12);
    for (int i = 0; i < NP; i++) begin
      if (((i / N_SYM) % 2) == 0) pl[i] = 9 + (i % N_SYM) - ((i % N_SYM) == 3 ? 2 : 0);
      else pl[i] = 29 + (i % N_SYM) - ((i % N_SYM) == 3 ? 1 : 0);
      gl[i] = 10 + (i % 5);
    end
    run_session("uneven", 1'b0);

    fill(10, 15, 12);
    run_session("implausible", 1'b0);

    fill(10, 30, 12);
    run_session("held_key", 1'b1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NP; i++) begin
        pl[i] = (((i / N_SYM) % 2) == 0) ? int'($urandom_range(3, 25)) : int'($urandom_range(8, 70));
        gl[i] = int'($urandom_range(2, 60));
      end
      run_session("random", 1'b0);
    end

    fill(10, 30, 12);
    start_pulse();
    tick(3);
    key_presses(5);
    n = 0;
    while (!bus.Error && n < 400) begin
      tick(1);
      n++;
    end
    check("abort_error", bus.Error, 1);
    check("abort_state", bus.state, 0);
    check("abort_valid", bus.Valid, 0);
    check("abort_busy", bus.Busy, 0);
    check("abort_late", (n >= 190) ? 1 : 0, 1);

    fill(10, 30, 12);
    start_pulse();
    tick(3);
    key_presses(N_SYM + 2);
    start_pulse();
    tick(1);
    check("busy_start_state", bus.state, 3);
    check("busy_start_sym", bus.sym_cnt, 2);
    check("busy_start_group", bus.group_cnt, 1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_sym", bus.sym_cnt, 0);
    check("mid_rst_group", bus.group_cnt, 0);
    check("mid_rst_valid", bus.Valid, 0);
    check("mid_rst_error", bus.Error, 0);
    check("mid_rst_thr", bus.Threshold, 0);
    tick(2);

    fill(10, 30, 12);
    run_session("after_reset", 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
